// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I-side / D-side memory port arbiter.
// Holds the cache-line type and the grant-side enum.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_LINE_W = 128;

  typedef logic [ARB_LINE_W-1:0] lc3b_c_line;

  typedef enum logic {
    arb_a = 1'b0,
    arb_b = 1'b1
  } lc3b_arb_side;

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Round-robin priority pick between the I-side (a) and D-side (b) requesters.
// Pure combinational function of the requests and the previous grant.
module arb_priority
  import mem_port_arbiter_pkg::*;
(
  input  logic         req_a,
  input  logic         req_b,
  input  lc3b_arb_side last_grant,
  output lc3b_arb_side grant,
  output logic         any_req
);

  // On conflict the side that was not served last wins, so neither side starves.
  always_comb begin
    grant   = last_grant;
    any_req = req_a | req_b;
    case ({req_a, req_b})
      2'b10:   grant = arb_a;
      2'b01:   grant = arb_b;
      2'b11:   grant = (last_grant == arb_a) ? arb_b : arb_a;
      default: grant = last_grant;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter_checker.sv
// Protocol checks for the memory port arbiter: requesters must hold their
// request while granted, and at most one response is ever issued per cycle.
module mem_port_arbiter_checker (
  input logic clk,
  input logic rst_n,
  input logic gnt_a,
  input logic gnt_b,
  input logic req_a,
  input logic req_b,
  input logic pmem_resp,
  input logic a_resp,
  input logic b_resp
);

  a_hold_req: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_a && !pmem_resp) |-> req_a);

  b_hold_req: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_b && !pmem_resp) |-> req_b);

  one_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(a_resp && b_resp));

  resp_to_granted: assert property (@(posedge clk) disable iff (!rst_n)
    (a_resp |-> gnt_a) and (b_resp |-> gnt_b));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single physical-memory port between the I-cache (a) and D-cache (b).
// A one-cycle RELEASE state after each response lets the served side drop its request.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic [ADDR_W-1:0] a_address,
  output logic [LINE_W-1:0] a_rdata,
  output logic              a_resp,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [LINE_W-1:0] b_wdata,
  output logic [LINE_W-1:0] b_rdata,
  output logic              b_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  arb_state_e   state_r;
  arb_state_e   state_nxt_s;
  lc3b_arb_side last_grant_r;
  lc3b_arb_side last_grant_nxt_s;
  lc3b_arb_side pick_s;
  logic         any_req_s;
  logic         req_a_s;
  logic         req_b_s;

  assign req_a_s = a_read;
  assign req_b_s = b_read | b_write;

  // Read data is broadcast; only the response pulse qualifies it.
  assign a_rdata = pmem_rdata;
  assign b_rdata = pmem_rdata;

  arb_priority u_arb_priority (
    .req_a      (req_a_s),
    .req_b      (req_b_s),
    .last_grant (last_grant_r),
    .grant      (pick_s),
    .any_req    (any_req_s)
  );

  // State and last-grant registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= arb_a;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Next-state logic and the downstream/response muxes.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = {ADDR_W{1'b0}};
    pmem_wdata       = {LINE_W{1'b0}};
    a_resp           = 1'b0;
    b_resp           = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          last_grant_nxt_s = pick_s;
          state_nxt_s      = (pick_s == arb_a) ? GRANT_A : GRANT_B;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_A: begin
        pmem_read    = a_read;
        pmem_address = a_address;
        if (pmem_resp) begin
          a_resp      = 1'b1;
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = GRANT_A;
        end
      end
      GRANT_B: begin
        pmem_address = b_address;
        pmem_wdata   = b_wdata;
        // A write takes precedence when the D-side raises both strobes.
        if (b_write) begin
          pmem_write = 1'b1;
        end else begin
          pmem_read = b_read;
        end
        if (pmem_resp) begin
          b_resp      = 1'b1;
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = GRANT_B;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  mem_port_arbiter_checker u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt_a     (state_r == GRANT_A),
    .gnt_b     (state_r == GRANT_B),
    .req_a     (req_a_s),
    .req_b     (req_b_s),
    .pmem_resp (pmem_resp),
    .a_resp    (a_resp),
    .b_resp    (b_resp)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk;
  logic              rst_n;
  logic              a_read;
  logic [ADDR_W-1:0] a_address;
  logic [LINE_W-1:0] a_rdata;
  logic              a_resp;
  logic              b_read;
  logic              b_write;
  logic [ADDR_W-1:0] b_address;
  logic [LINE_W-1:0] b_wdata;
  logic [LINE_W-1:0] b_rdata;
  logic              b_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_checks;
  int n_errors;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_read       (a_read),
    .a_address    (a_address),
    .a_rdata      (a_rdata),
    .a_resp       (a_resp),
    .b_read       (b_read),
    .b_write      (b_write),
    .b_address    (b_address),
    .b_wdata      (b_wdata),
    .b_rdata      (b_rdata),
    .b_resp       (b_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_b;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    a_read     = 1'b0;
    a_address  = 16'h0000;
    b_read     = 1'b0;
    b_write    = 1'b0;
    b_address  = 16'h0000;
    b_wdata    = {LINE_W{1'b0}};
    pmem_rdata = {LINE_W{1'b0}};
    pmem_resp  = 1'b0;

    // Reset state
    #2;
    check_val("rst_pmem_read", pmem_read, 128'd0);
    check_val("rst_pmem_write", pmem_write, 128'd0);
    check_val("rst_pmem_address", pmem_address, 128'd0);
    check_val("rst_resp", {a_resp, b_resp}, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single I-side read
    a_read    = 1'b1;
    a_address = 16'h1230;
    #1;
    check_val("a_idle_no_strobe", pmem_read, 128'd0);
    tick();
    check_val("a_pmem_read", pmem_read, 128'd1);
    check_val("a_pmem_address", pmem_address, 128'h1230);
    check_val("a_pmem_write", pmem_write, 128'd0);
    check_val("a_resp_early", a_resp, 128'd0);
    tick();
    tick();
    check_val("a_pmem_read_held", pmem_read, 128'd1);
    pmem_rdata = 128'h0123456789abcdef_fedcba9876543210;
    pmem_resp  = 1'b1;
    #1;
    check_val("a_resp_pulse", a_resp, 128'd1);
    check_val("a_resp_b_quiet", b_resp, 128'd0);
    check_val("a_rdata", a_rdata, 128'h0123456789abcdef_fedcba9876543210);
    tick();
    pmem_resp = 1'b0;
    a_read    = 1'b0;
    #1;
    check_val("a_release_resp", a_resp, 128'd0);
    check_val("a_release_read", pmem_read, 128'd0);
    tick();
    check_val("a_idle_read", pmem_read, 128'd0);

    // D-side write with read also high; then stale b_read held through RELEASE
    b_write   = 1'b1;
    b_read    = 1'b1;
    b_address = 16'h4000;
    b_wdata   = {16{8'hA5}};
    tick();
    check_val("b_pmem_write", pmem_write, 128'd1);
    check_val("b_pmem_read", pmem_read, 128'd0);
    check_val("b_pmem_wdata", pmem_wdata, {16{8'hA5}});
    check_val("b_pmem_address", pmem_address, 128'h4000);
    pmem_rdata = 128'h5a5a5a5a_00000000_ffffffff_12345678;
    pmem_resp  = 1'b1;
    #1;
    check_val("b_resp_pulse", b_resp, 128'd1);
    check_val("b_resp_a_quiet", a_resp, 128'd0);
    check_val("b_rdata", b_rdata, 128'h5a5a5a5a_00000000_ffffffff_12345678);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_val("b_release_resp", b_resp, 128'd0);
    check_val("b_release_strobes", {pmem_read, pmem_write}, 128'd0);
    check_val("b_release_wdata", pmem_wdata, 128'd0);
    tick();
    b_read  = 1'b0;
    b_write = 1'b0;
    #1;
    check_val("b_idle_strobes", {pmem_read, pmem_write}, 128'd0);
    tick();
    check_val("b_no_regrant", {pmem_read, pmem_write}, 128'd0);

    // Contention after reset: alternation B, A, B, A, B, A
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    a_read    = 1'b1;
    a_address = 16'h1000;
    b_read    = 1'b1;
    b_address = 16'h2000;
    for (int i = 0; i < 6; i++) begin
      exp_b = (i % 2 == 0);
      tick();
      check_val($sformatf("cont%0d_addr", i), pmem_address, exp_b ? 128'h2000 : 128'h1000);
      check_val($sformatf("cont%0d_read", i), pmem_read, 128'd1);
      pmem_resp = 1'b1;
      #1;
      check_val($sformatf("cont%0d_resp", i), {a_resp, b_resp}, exp_b ? 128'b01 : 128'b10);
      tick();
      pmem_resp = 1'b0;
      if (exp_b) b_read = 1'b0;
      else       a_read = 1'b0;
      #1;
      check_val($sformatf("cont%0d_release", i), pmem_read, 128'd0);
      tick();
      if (exp_b) b_read = 1'b1;
      else       a_read = 1'b1;
      #1;
      check_val($sformatf("cont%0d_idle", i), pmem_read, 128'd0);
    end
    a_read = 1'b0;
    b_read = 1'b0;
    tick();
    check_val("cont_done", pmem_read, 128'd0);

    // Reset in the middle of an I-side grant
    a_read    = 1'b1;
    a_address = 16'h5550;
    tick();
    check_val("mid_grant_read", pmem_read, 128'd1);
    #1;
    rst_n  = 1'b0;
    a_read = 1'b0;
    #1;
    check_val("mid_rst_read", pmem_read, 128'd0);
    check_val("mid_rst_address", pmem_address, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pmem_resp = 1'b1;
    #1;
    check_val("late_resp_a", a_resp, 128'd0);
    tick();
    pmem_resp = 1'b0;

    // Spurious downstream response in IDLE
    pmem_resp = 1'b1;
    #1;
    check_val("spur_resp", {a_resp, b_resp}, 128'd0);
    check_val("spur_strobes", {pmem_read, pmem_write}, 128'd0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_val("spur_after", {pmem_read, pmem_write, a_resp, b_resp}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache side (port a) and the data-cache side (port b) of the pipelined LC-3b core.
- Each requester holds its request until it receives a one-cycle response. The arbiter grants exactly one requester at a time, forwards that requester's request downstream, and routes the downstream response back.
- Ports a and b produce mem_resp_a and mem_resp_b. The LDI/STI stall controller and the fetch stall logic consume these responses unchanged.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word)
- LINE_W, 128, cache-line width transferred per access

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- a_read  in  1  I-side line read request, held until a_resp
- a_address  in  ADDR_W  I-side line address, stable while a_read is high
- a_rdata  out  LINE_W  read line to the I-side
- a_resp  out  1  one-cycle completion pulse to the I-side
- b_read  in  1  D-side line read request, held until b_resp
- b_write  in  1  D-side line write request, held until b_resp
- b_address  in  ADDR_W  D-side line address
- b_wdata  in  LINE_W  D-side write line
- b_rdata  out  LINE_W  read line to the D-side
- b_resp  out  1  one-cycle completion pulse to the D-side
- pmem_read  out  1  downstream read strobe
- pmem_write  out  1  downstream write strobe
- pmem_address  out  ADDR_W  downstream address
- pmem_wdata  out  LINE_W  downstream write data
- pmem_rdata  in  LINE_W  downstream read data
- pmem_resp  in  1  downstream completion, one cycle

Behaviour:
- State machine: IDLE, GRANT_A, GRANT_B, RELEASE.
- Registers:
  - state (reset IDLE)
  - last_grant (1 bit, reset = A)
- Reset: asynchronous on rst_n low; all outputs take their IDLE values immediately. Reset mid-transfer abandons the transfer; no response is issued afterwards.
- IDLE outputs:
  - pmem_read = 0, pmem_write = 0
  - pmem_address = 0, pmem_wdata = 0
  - a_resp = 0, b_resp = 0
- Request definitions: req_a = a_read; req_b = b_read | b_write.
- IDLE transitions:
  - Only req_a → GRANT_A.
  - Only req_b → GRANT_B.
  - Both → grant the side that is not last_grant. With the reset value of last_grant, the first conflict goes to B.
  - On entering a grant state, last_grant is updated to that side.
- GRANT_A:
  - pmem_read = a_read; pmem_address = a_address; pmem_write = 0.
  - On pmem_resp: a_resp = 1 (combinational, same cycle), then → RELEASE.
- GRANT_B:
  - pmem_address = b_address; pmem_wdata = b_wdata.
  - If b_write = 1: pmem_write = 1, pmem_read = 0. Write wins if both b_read and b_write are high.
  - Else: pmem_read = b_read.
  - On pmem_resp: b_resp = 1, then → RELEASE.
- RELEASE: all strobes 0 and resp 0 for exactly one cycle, then → IDLE. This lets the served requester drop its request, so a stale request is never re-granted.
- Requester withdrawal: if the granted request drops before pmem_resp (illegal), the downstream strobe drops with it and the state is held. An assertion flags this case.
- a_rdata = b_rdata = pmem_rdata at all times, unregistered. Only the resp pulse qualifies the data.
- a_resp and b_resp are never high in the same cycle. A resp is never issued to the non-granted side.
- pmem_resp received in IDLE or RELEASE is ignored.
- Latency: request seen in IDLE → strobe asserted on the next cycle. Minimum gap between back-to-back grants is 2 cycles (RELEASE + IDLE).
- No starvation: under continuous contention the grants strictly alternate A, B, A, B.

Decomposition:
- lc3b_types gains:
  - lc3b_c_line (LINE_W vector)
  - enum lc3b_arb_side {arb_a, arb_b} for last_grant
- The state enum stays local to the module.
- Natural sub-module: arb_priority. A pure function of (req_a, req_b, last_grant) → grant side; it is exhaustively testable on its own.
- The top level holds the FSM and the muxes.

Test Plan:
- Reset → all strobes and resp = 0, state IDLE. Release rst_n, then a_read = 1, a_address = 0x1230 → pmem_read = 1, pmem_address = 0x1230 next cycle. pmem_resp at cycle 4 → a_resp = 1 that cycle only, a_rdata = pmem_rdata.
- b_write = 1, b_read = 1, b_address = 0x4000, b_wdata = 0xA5…A5 → pmem_write = 1, pmem_read = 0, pmem_wdata = 0xA5…A5. b_resp = 1 for one cycle, then RELEASE with strobes 0.
- a_read and b_read raised in the same cycle after reset → B granted first. A granted after B's resp + 2 cycles. Continuous contention over 6 grants → order B, A, B, A, B, A.
- b_read held high through resp and RELEASE, dropped the cycle after resp → no second grant to B.
- Assert rst_n = 0 mid-GRANT_A, before pmem_resp → pmem_read = 0 asynchronously. After release, a late pmem_resp pulse produces no a_resp.
- Spurious pmem_resp in IDLE → a_resp = b_resp = 0 and state unchanged.
